imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 183 ++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// RV32/RV64 immediate decoder behind a valid/ready output register with a one-entry skid buffer.
// Optional CSR zimm decoding is enabled by defining IMM_GEN_ZIMM_EN.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
`ifdef IMM_GEN_ZIMM_EN
    localparam logic [2:0] FMT_Z    = 3'd6;
`endif

    // Bit 0 means "output register full", bit 1 means "skid full".
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b11
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [XLEN-1:0]   r_out_imm;
    logic [2:0]        r_out_fmt;
    logic [TAG_W-1:0]  r_out_tag;
    logic [XLEN-1:0]   r_skid_imm;
    logic [2:0]        r_skid_fmt;
    logic [TAG_W-1:0]  r_skid_tag;

    logic [XLEN-1:0]   w_dec_imm;
    logic [2:0]        w_dec_fmt;
    logic [6:0]        w_opcode;
    logic              w_sign;
    logic              w_in_xfer;
    logic              w_out_xfer;
    logic              w_load_out_in;
    logic              w_load_out_skid;
    logic              w_load_skid;

    assign w_opcode = in_instr[6:0];
    assign w_sign   = in_instr[31];

    always_comb begin
        w_dec_imm = '0;
        w_dec_fmt = FMT_NONE;
        case (w_opcode)
            7'b0000011, 7'b0010011, 7'b1100111: begin
                w_dec_imm = {{(XLEN-12){w_sign}}, in_instr[31:20]};
                w_dec_fmt = FMT_I;
            end
            7'b0100011: begin
                w_dec_imm = {{(XLEN-12){w_sign}}, in_instr[31:25], in_instr[11:7]};
                w_dec_fmt = FMT_S;
            end
            7'b1100011: begin
                w_dec_imm = {{(XLEN-13){w_sign}}, in_instr[31], in_instr[7],
                             in_instr[30:25], in_instr[11:8], 1'b0};
                w_dec_fmt = FMT_B;
            end
            7'b0110111, 7'b0010111: begin
                w_dec_imm = {{(XLEN-32){w_sign}}, in_instr[31:12], 12'b0};
                w_dec_fmt = FMT_U;
            end
            7'b1101111: begin
                w_dec_imm = {{(XLEN-21){w_sign}}, in_instr[31], in_instr[19:12],
                             in_instr[20], in_instr[30:21], 1'b0};
                w_dec_fmt = FMT_J;
            end
`ifdef IMM_GEN_ZIMM_EN
            // Only the immediate CSR forms (funct3[2] set) carry a zimm in rs1.
            7'b1110011: begin
                if (in_instr[14]) begin
                    w_dec_imm = {{(XLEN-5){1'b0}}, in_instr[19:15]};
                    w_dec_fmt = FMT_Z;
                end
            end
`endif
            default: begin
                w_dec_imm = '0;
                w_dec_fmt = FMT_NONE;
            end
        endcase
    end

    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_load_out_in   = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_xfer) begin
                    w_state_next  = ST_ONE;
                    w_load_out_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_load_out_in = 1'b1;
                end else if (w_in_xfer) begin
                    w_state_next = ST_TWO;
                    w_load_skid  = 1'b1;
                end else if (w_out_xfer) begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_out_xfer) begin
                    w_state_next    = ST_ONE;
                    w_load_out_skid = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
            end
        endcase
    end

    // Both handshake outputs come straight from state flops, so out_ready never reaches in_ready.
    always_comb begin
        out_valid = r_state[0];
        in_ready  = !r_state[1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_imm  <= '0;
            r_out_fmt  <= FMT_NONE;
            r_out_tag  <= '0;
            r_skid_imm <= '0;
            r_skid_fmt <= FMT_NONE;
            r_skid_tag <= '0;
        end else begin
            if (w_load_out_in) begin
                r_out_imm <= w_dec_imm;
                r_out_fmt <= w_dec_fmt;
                r_out_tag <= in_tag;
            end else if (w_load_out_skid) begin
                r_out_imm <= r_skid_imm;
                r_out_fmt <= r_skid_fmt;
                r_out_tag <= r_skid_tag;
            end
            if (w_load_skid) begin
                r_skid_imm <= w_dec_imm;
                r_skid_fmt <= w_dec_fmt;
                r_skid_tag <= in_tag;
            end
        end
    end

    assign out_imm = r_out_imm;
    assign out_fmt = r_out_fmt;
    assign out_tag = r_out_tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances run in lockstep on one stimulus.
// Expected zimm results follow whether IMM_GEN_ZIMM_EN is defined for the build.
module tb_imm_gen_pipe;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [4:0]  tag;
        int          cyc;
        bit          lat1;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [4:0]  in_tag;
    logic        out_ready;

    logic        in_ready32, out_valid32;
    logic [31:0] out_imm32;
    logic [2:0]  out_fmt32;
    logic [4:0]  out_tag32;
    logic        in_ready64, out_valid64;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt64;
    logic [4:0]  out_tag64;

    exp_t q32[$];
    exp_t q64[$];
    int   checks;
    int   errors;
    int   cyc;

    logic [70:0] snap32, snap64;
    bit          snap32_v, snap64_v;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5)) u_dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_fmt(out_fmt32), .out_tag(out_tag32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(5)) u_dut64 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_fmt(out_fmt64), .out_tag(out_tag64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction and record its expected result on the accepting edge.
    task automatic send(input logic [31:0] instr, input logic [4:0] tag,
                        input logic [63:0] imm, input logic [2:0] fmt, input bit lat1);
        exp_t e;
        int   waited;
        in_valid = 1'b1;
        in_instr = instr;
        in_tag   = tag;
        waited   = 0;
        while (!in_ready32 && waited < 20) begin
            tick();
            waited++;
        end
        if (!in_ready32) begin
            chk("send_timeout", 64'(in_ready32), 64'd1);
        end else begin
            e.imm  = imm;
            e.fmt  = fmt;
            e.tag  = tag;
            e.cyc  = cyc;
            e.lat1 = lat1;
            @(posedge clk);
            q32.push_back(e);
            q64.push_back(e);
            #1;
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                snap32_v = 1'b0;
                snap64_v = 1'b0;
            end else begin
                if (out_valid32 && out_ready) begin
                    if (q32.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected32 actual=tag %0d imm 0x%0h required=no output", out_tag32, out_imm32);
                    end else begin
                        e = q32.pop_front();
                        chk("imm32", 64'(out_imm32), {32'b0, e.imm[31:0]});
                        chk("fmt32", 64'(out_fmt32), 64'(e.fmt));
                        chk("tag32", 64'(out_tag32), 64'(e.tag));
                        if (e.lat1) chk("latency32", 64'(cyc), 64'(e.cyc + 1));
                    end
                end
                if (out_valid64 && out_ready) begin
                    if (q64.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected64 actual=tag %0d imm 0x%0h required=no output", out_tag64, out_imm64);
                    end else begin
                        e = q64.pop_front();
                        chk("imm64", out_imm64, e.imm);
                        chk("fmt64", 64'(out_fmt64), 64'(e.fmt));
                        chk("tag64", 64'(out_tag64), 64'(e.tag));
                        if (e.lat1) chk("latency64", 64'(cyc), 64'(e.cyc + 1));
                    end
                end
                if (out_valid32 && !out_ready) begin
                    if (snap32_v) chk("hold32", {32'b0, out_imm32, out_fmt32, out_tag32}, snap32);
                    snap32   = {32'b0, out_imm32, out_fmt32, out_tag32};
                    snap32_v = 1'b1;
                end else begin
                    snap32_v = 1'b0;
                end
                if (out_valid64 && !out_ready) begin
                    if (snap64_v) chk("hold64", {out_imm64, out_fmt64, out_tag64}, snap64);
                    snap64   = {out_imm64, out_fmt64, out_tag64};
                    snap64_v = 1'b1;
                end else begin
                    snap64_v = 1'b0;
                end
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        snap32_v  = 1'b0;
        snap64_v  = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        in_tag    = 5'd0;
        out_ready = 1'b1;
        fork
            monitor();
        join_none

        #1;
        chk("rst_out_valid", 64'(out_valid32), 64'd0);
        chk("rst_in_ready", 64'(in_ready32), 64'd1);
        chk("rst_out_imm", {32'b0, out_imm32}, 64'd0);
        chk("rst_out_fmt", 64'(out_fmt32), 64'd0);
        chk("rst_out_tag", 64'(out_tag32), 64'd0);
        chk("rst_out_imm64", out_imm64, 64'd0);
        tick();
        tick();
        rst = 1'b0;

        // Back-to-back stream, accepted from the first cycle after reset release.
        send(32'hFFF00093, 5'd1, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b1);
        send(32'hFE112E23, 5'd2, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b1);
        send(32'hFE000CE3, 5'd3, 64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b1);
        send(32'h123452B7, 5'd4, 64'h0000000012345000, 3'd4, 1'b1);
        send(32'h0010006F, 5'd5, 64'h0000000000000800, 3'd5, 1'b1);
        send(32'h80000037, 5'd6, 64'hFFFFFFFF80000000, 3'd4, 1'b1);
        send(32'h002081B3, 5'd7, 64'h0, 3'd0, 1'b1);
        send(32'h80002083, 5'd8, 64'hFFFFFFFFFFFFF800, 3'd1, 1'b1);
        send(32'h7FF08067, 5'd9, 64'h00000000000007FF, 3'd1, 1'b1);
        send(32'hFFFFF197, 5'd10, 64'hFFFFFFFFFFFFF000, 3'd4, 1'b1);
        send(32'h00208463, 5'd11, 64'h0000000000000008, 3'd3, 1'b1);
        send(32'h00112623, 5'd12, 64'h000000000000000C, 3'd2, 1'b1);
        send(32'hFFDFF0EF, 5'd13, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b1);
`ifdef IMM_GEN_ZIMM_EN
        send(32'h3400D073, 5'd14, 64'h1, 3'd6, 1'b1);
`else
        send(32'h3400D073, 5'd14, 64'h0, 3'd0, 1'b1);
`endif
        send(32'h34009073, 5'd15, 64'h0, 3'd0, 1'b1);
        in_valid = 1'b0;
        repeat (3) tick();

        // Backpressure: fill output register and skid, then drain.
        out_ready = 1'b0;
        send(32'h00100093, 5'd1, 64'h1, 3'd1, 1'b0);
        send(32'h00200093, 5'd2, 64'h2, 3'd1, 1'b0);
        in_valid = 1'b1;
        in_instr = 32'h00300093;
        in_tag   = 5'd3;
        chk("full_in_ready", 64'(in_ready32), 64'd0);
        repeat (3) tick();
        chk("full_in_ready_hold", 64'(in_ready32), 64'd0);
        chk("full_out_tag", 64'(out_tag32), 64'd1);
        out_ready = 1'b1;
        chk("drain_valid1", 64'(out_valid32), 64'd1);
        tick();
        chk("drain_tag2", 64'(out_tag32), 64'd2);
        chk("drain_valid2", 64'(out_valid32), 64'd1);
        chk("drain_in_ready", 64'(in_ready32), 64'd1);
        begin
            exp_t e;
            e.imm = 64'h3; e.fmt = 3'd1; e.tag = 5'd3; e.cyc = cyc; e.lat1 = 1'b1;
            @(posedge clk);
            q32.push_back(e);
            q64.push_back(e);
            #1;
        end
        in_valid = 1'b0;
        chk("drain_tag3", 64'(out_tag32), 64'd3);
        chk("drain_valid3", 64'(out_valid32), 64'd1);
        repeat (2) tick();

        // Asynchronous reset while two entries are held.
        out_ready = 1'b0;
        send(32'h00500093, 5'd20, 64'h5, 3'd1, 1'b0);
        send(32'h00600093, 5'd21, 64'h6, 3'd1, 1'b0);
        in_valid = 1'b0;
        chk("two_in_ready", 64'(in_ready32), 64'd0);
        chk("two_out_valid", 64'(out_valid32), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid32), 64'd0);
        chk("arst_in_ready", 64'(in_ready32), 64'd1);
        chk("arst_out_imm", {32'b0, out_imm32}, 64'd0);
        chk("arst_out_valid64", 64'(out_valid64), 64'd0);
        q32.delete();
        q64.delete();
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send(32'h00700093, 5'd22, 64'h7, 3'd1, 1'b1);
        in_valid = 1'b0;
        repeat (4) tick();
        chk("no_stale_valid", 64'(out_valid32), 64'd0);
        chk("q32_drained", 64'(q32.size()), 64'd0);
        chk("q64_drained", 64'(q64.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
